// File: rtl/mskand_hpc3_sched_pkg.sv
// Shared types and sizing helpers for the masked-AND gadget scheduler.
package mskand_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_e;

  function automatic int rndw(input int d);
    return d * (d - 1);
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mskand_hpc3_sched_if.sv
// Requester, randomness, gadget and response signals of the scheduler.
interface mskand_hpc3_sched_if #(
  parameter int d    = 2,
  parameter int NREQ = 4
);
  import mskand_sched_pkg::*;

  localparam int RNDW = rndw(d);

  // A requester operation transfers in a cycle where req_valid[i] & req_ready[i];
  // randomness transfers where rnd_valid & rnd_ready. Ready never waits on a
  // later cycle, and valid must not depend on ready.
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*d-1:0] req_a;
  logic [NREQ*d-1:0] req_b;
  logic              rnd_valid;
  logic              rnd_ready;
  logic [RNDW-1:0]   rnd_in;
  logic [d-1:0]      g_ina;
  logic [d-1:0]      g_inb;
  logic [RNDW-1:0]   g_rnd;
  logic [d-1:0]      g_out;
  logic [NREQ-1:0]   resp_valid;
  logic [d-1:0]      resp_out;
  state_e            dbg_state;

  modport master (
    input  req_valid, req_a, req_b, rnd_valid, rnd_in, g_out,
    output req_ready, rnd_ready, g_ina, g_inb, g_rnd, resp_valid, resp_out, dbg_state
  );

  modport slave (
    output req_valid, req_a, req_b, rnd_valid, rnd_in, g_out,
    input  req_ready, rnd_ready, g_ina, g_inb, g_rnd, resp_valid, resp_out, dbg_state
  );

endinterface

// File: rtl/mskand_hpc3_sched_rr_arbiter.sv
// Combinational round-robin arbiter: lowest requesting index >= ptr, wrapping,
// with an optional exclusion mask.
module rr_arbiter
  import mskand_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDXW = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDXW-1:0] ptr_i,
  input  logic [NREQ-1:0] excl_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDXW-1:0] idx_o,
  output logic            any_o
);

  logic [NREQ-1:0] req_m;
  logic [IDXW-1:0] lo_idx;
  logic [IDXW-1:0] hi_idx;
  logic            hi_found;

  assign req_m = req_i & ~excl_i;

  // Descending scans leave the lowest match, with and without the ptr bound.
  always_comb begin
    lo_idx   = '0;
    hi_idx   = '0;
    hi_found = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_m[i]) begin
        lo_idx = IDXW'(i);
      end
      if (req_m[i] && (IDXW'(i) >= ptr_i)) begin
        hi_idx   = IDXW'(i);
        hi_found = 1'b1;
      end
    end
  end

  assign any_o   = |req_m;
  assign idx_o   = hi_found ? hi_idx : lo_idx;
  assign grant_o = any_o ? (NREQ'(1) << idx_o) : '0;

endmodule

// File: rtl/mskand_hpc3_sched.sv
// Time-shares one latency-1 masked HPC3 AND gadget between NREQ requesters,
// with registered gadget inputs and a zero guard cycle on every owner change.
module mskand_hpc3_sched
  import mskand_sched_pkg::*;
#(
  parameter int d      = 2,
  parameter int NREQ   = 4,
  parameter int MAXRUN = 8
) (
  input logic                clk,
  input logic                rst_n,
  mskand_hpc3_sched_if.master bus
);

  localparam int RNDW = rndw(d);
  localparam int IDXW = idx_w(NREQ);
  localparam int RUNW = $clog2(MAXRUN + 1);

  state_e          state_q, state_d;
  logic [IDXW-1:0] owner_q, owner_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [RUNW-1:0] run_q, run_d;
  logic [NREQ-1:0] tag1_q, tag2_q;
  logic [d-1:0]    ina_q, inb_q;
  logic [RNDW-1:0] rnd_q;

  logic [NREQ-1:0] owner_oh, excl, arb_grant, win_oh;
  logic [IDXW-1:0] arb_idx, win_idx;
  logic            arb_any, keep_owner, win_any, can_issue, issue;
  logic [d-1:0]    sel_a, sel_b;

  assign owner_oh = NREQ'(1) << owner_q;

  // A saturated owner steps aside only while someone else is actually waiting.
  assign excl = ((state_q == RUN) && (run_q == RUNW'(MAXRUN)) &&
                 (|(bus.req_valid & ~owner_oh))) ? owner_oh : '0;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_arb (
    .req_i   (bus.req_valid),
    .ptr_i   (ptr_q),
    .excl_i  (excl),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .any_o   (arb_any)
  );

  // While streaming, the owner keeps the gadget until it drops or hits the run limit.
  assign keep_owner = (state_q == RUN) && (|(bus.req_valid & owner_oh)) && (excl == '0);
  assign win_idx    = keep_owner ? owner_q : arb_idx;
  assign win_oh     = keep_owner ? owner_oh : arb_grant;
  assign win_any    = keep_owner | arb_any;
  assign can_issue  = bus.rnd_valid & win_any;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    run_d   = run_q;
    issue   = 1'b0;
    case (state_q)
      RUN: begin
        if (!can_issue) begin
          state_d = IDLE;
        end else if (keep_owner) begin
          issue = 1'b1;
          run_d = (run_q == RUNW'(MAXRUN)) ? run_q : run_q + 1'b1;
        end else begin
          state_d = GAP;
        end
      end
      default: begin
        if (can_issue) begin
          issue   = 1'b1;
          state_d = RUN;
          owner_d = win_idx;
          run_d   = RUNW'(1);
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    if (issue) begin
      ptr_d = (win_idx == IDXW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IDXW'(i)) begin
        sel_a = bus.req_a[i*d +: d];
        sel_b = bus.req_b[i*d +: d];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      run_q   <= '0;
      ina_q   <= '0;
      inb_q   <= '0;
      rnd_q   <= '0;
      tag1_q  <= '0;
      tag2_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      run_q   <= run_d;
      ina_q   <= issue ? sel_a : '0;
      inb_q   <= issue ? sel_b : '0;
      rnd_q   <= issue ? bus.rnd_in : '0;
      tag1_q  <= issue ? win_oh : '0;
      tag2_q  <= tag1_q;
    end
  end

  // Handshake outputs are forced low while reset is asserted, even with requests pending.
  assign bus.req_ready  = (issue && rst_n) ? win_oh : '0;
  assign bus.rnd_ready  = issue & rst_n;
  assign bus.g_ina      = ina_q;
  assign bus.g_inb      = inb_q;
  assign bus.g_rnd      = rnd_q;
  assign bus.resp_valid = tag2_q;
  assign bus.resp_out   = (|tag2_q) ? bus.g_out : '0;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_mskand_hpc3_sched.sv
// Bench for mskand_hpc3_sched: directed scenarios with literal expectations plus
// a randomized run against a cycle-level behavioural scheduling model.
module tb_mskand_hpc3_sched;
  import mskand_sched_pkg::*;

  localparam int D      = 2;
  localparam int NREQ   = 4;
  localparam int MAXRUN = 8;
  localparam int RNDW   = D * (D - 1);
  localparam int AW     = NREQ * D;
  localparam int GW     = 2 * D + RNDW;
  localparam int RW     = NREQ + D + 1;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mskand_hpc3_sched_if #(.d(D), .NREQ(NREQ)) bus ();

  mskand_hpc3_sched #(
    .d      (D),
    .NREQ   (NREQ),
    .MAXRUN (MAXRUN)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Gadget stand-in: one register stage, output shares XOR to unmask(a)&unmask(b).
  function automatic logic [D-1:0] gadget(input logic [D-1:0] a, input logic [D-1:0] b,
                                          input logic [RNDW-1:0] r);
    logic [D-1:0] o;
    logic acc;
    o   = '0;
    acc = (^a) & (^b);
    for (int k = 1; k < D; k++) begin
      o[k] = r[k-1];
      acc  = acc ^ r[k-1];
    end
    o[0] = acc;
    return o;
  endfunction

  logic [D-1:0] g_out_q = '0;
  always @(posedge clk) g_out_q <= gadget(bus.g_ina, bus.g_inb, bus.g_rnd);
  assign bus.g_out = g_out_q;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [GW-1:0] exp_q[$];
  logic [RW-1:0] exp_r_q[$];

  int m_ptr;
  int m_owner;
  int m_run;
  bit m_streaming;

  task automatic model_reset();
    m_ptr       = 0;
    m_owner     = 0;
    m_run       = 0;
    m_streaming = 1'b0;
    exp_q.delete();
    exp_r_q.delete();
    exp_q.push_back('0);
    exp_r_q.push_back('0);
    exp_r_q.push_back('0);
  endtask

  // Which requester is served this cycle (-1 for none), from the scheduling rules.
  function automatic int predict();
    logic others;
    if (!bus.rnd_valid || (bus.req_valid == '0)) return -1;
    if (m_streaming) begin
      others = (bus.req_valid & ~(NREQ'(1) << m_owner)) != '0;
      if (bus.req_valid[m_owner] && !((m_run >= MAXRUN) && others)) return m_owner;
      return -1;
    end
    for (int k = 0; k < NREQ; k++) begin
      if (bus.req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  initial model_reset();

  always @(negedge clk) begin : cmp
    int g;
    logic [GW-1:0]   gi;
    logic [RW-1:0]   ri;
    logic [D-1:0]    a, b;
    logic [RNDW-1:0] r;
    if (!rst_n) begin
      chk("rst_req_ready", 32'(bus.req_ready), 0);
      chk("rst_rnd_ready", 32'(bus.rnd_ready), 0);
      chk("rst_g_ina", 32'(bus.g_ina), 0);
      chk("rst_g_inb", 32'(bus.g_inb), 0);
      chk("rst_g_rnd", 32'(bus.g_rnd), 0);
      chk("rst_resp_valid", 32'(bus.resp_valid), 0);
      chk("rst_resp_out", 32'(bus.resp_out), 0);
      model_reset();
    end else begin
      g = predict();
      chk("req_ready", 32'(bus.req_ready), (g >= 0) ? 32'(NREQ'(1) << g) : 0);
      chk("rnd_ready", 32'(bus.rnd_ready), (g >= 0) ? 1 : 0);
      gi = exp_q.pop_front();
      chk("g_ina", 32'(bus.g_ina), 32'(gi[GW-1 -: D]));
      chk("g_inb", 32'(bus.g_inb), 32'(gi[RNDW +: D]));
      chk("g_rnd", 32'(bus.g_rnd), 32'(gi[RNDW-1:0]));
      ri = exp_r_q.pop_front();
      chk("resp_valid", 32'(bus.resp_valid), 32'(ri[RW-1 -: NREQ]));
      chk("resp_out", 32'(bus.resp_out), 32'(ri[D:1]));
      if (ri[RW-1 -: NREQ] != '0) chk("resp_unmask", 32'(^bus.resp_out), 32'(ri[0]));
      if (g >= 0) begin
        m_run       = (m_streaming && (g == m_owner)) ? m_run + 1 : 1;
        m_owner     = g;
        m_ptr       = (g + 1) % NREQ;
        m_streaming = 1'b1;
        a = bus.req_a[g*D +: D];
        b = bus.req_b[g*D +: D];
        r = bus.rnd_in;
        exp_q.push_back({a, b, r});
        exp_r_q.push_back({NREQ'(1) << g, gadget(a, b, r), (^a) & (^b)});
      end else begin
        m_streaming = 1'b0;
        exp_q.push_back('0);
        exp_r_q.push_back('0);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rnd_valid = 1'b0;
    bus.rnd_in    = '0;

    // Reset with every requester and randomness pending.
    tick();
    bus.req_valid = '1;
    bus.rnd_valid = 1'b1;
    bus.req_a     = '1;
    @(negedge clk);
    chk("reset_req_ready", 32'(bus.req_ready), 0);
    chk("reset_state", 32'(bus.dbg_state), 32'(IDLE));
    tick();
    bus.req_valid = '0;
    rst_n = 1'b1;
    tick();

    // Requester 0 alone, three back-to-back ops.
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_a[1:0] = 2'b01;
    bus.req_b[1:0] = 2'b11;
    bus.rnd_in     = 2'b01;
    bus.req_valid  = 4'b0001;
    @(negedge clk); chk("t1_grant0", 32'(bus.req_ready), 'b0001);
    tick(); @(negedge clk); chk("t1_ina_t1", 32'(bus.g_ina), 'b01);
    tick(); @(negedge clk); chk("t1_ina_t2", 32'(bus.g_ina), 'b01);
    chk("t1_resp_t2", 32'(bus.resp_valid), 'b0001);
    chk("t1_resp_out", 32'(bus.resp_out), 'b11);
    tick(); bus.req_valid = '0;
    @(negedge clk); chk("t1_ina_t3", 32'(bus.g_ina), 'b01);
    chk("t1_resp_t3", 32'(bus.resp_valid), 'b0001);
    tick(); @(negedge clk); chk("t1_ina_zero", 32'(bus.g_ina), 0);
    chk("t1_resp_t4", 32'(bus.resp_valid), 'b0001);
    tick(); @(negedge clk); chk("t1_resp_done", 32'(bus.resp_valid), 0);

    // Reset one cycle after an issue; ptr is 1 here so requester 1 wins.
    tick();
    bus.req_a = '1;
    bus.req_b = '1;
    bus.req_valid = 4'b0010;
    @(negedge clk); chk("t5_grant1", 32'(bus.req_ready), 'b0010);
    tick();
    bus.req_valid = 4'b0101;
    rst_n = 1'b0;
    @(negedge clk); chk("t5_async_ina", 32'(bus.g_ina), 0);
    chk("t5_async_ready", 32'(bus.req_ready), 0);
    tick(); @(negedge clk); chk("t5_no_resp", 32'(bus.resp_valid), 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk); chk("t5_first_grant0", 32'(bus.req_ready), 'b0001);
    chk("t5_no_resp_after", 32'(bus.resp_valid), 0);

    // Requesters 0 and 2; owner 0 drops, one guard cycle, then requester 2.
    tick(); @(negedge clk); chk("t2_hold0", 32'(bus.req_ready), 'b0001);
    tick(); bus.req_valid = 4'b0100;
    @(negedge clk); chk("t2_switch_wait", 32'(bus.req_ready), 0);
    tick(); @(negedge clk); chk("t2_gap_ina", 32'(bus.g_ina), 0);
    chk("t2_gap_inb", 32'(bus.g_inb), 0);
    chk("t2_grant2", 32'(bus.req_ready), 'b0100);
    tick(); bus.req_valid = '0;
    @(negedge clk); chk("t2_ina2", 32'(bus.g_ina), 'b11);
    tick(); @(negedge clk); chk("t2_resp2", 32'(bus.resp_valid), 'b0100);

    // Bring ptr to 1, then requesters 1 and 3 contend continuously.
    tick(); bus.req_valid = 4'b0001;
    tick(); bus.req_valid = '0;
    tick(); bus.req_valid = 4'b1010;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k < 8 || k >= 18)          chk("t3_owner1", 32'(bus.req_ready), 'b0010);
      else if (k == 8 || k == 17)    chk("t3_gap", 32'(bus.req_ready), 0);
      else                           chk("t3_owner3", 32'(bus.req_ready), 'b1000);
      tick();
    end

    // Randomness withheld for two cycles while requests stay pending.
    bus.rnd_valid = 1'b0;
    @(negedge clk); chk("t4_ready0", 32'(bus.req_ready), 0);
    chk("t4_rnd_ready0", 32'(bus.rnd_ready), 0);
    tick(); @(negedge clk); chk("t4_ina_zero", 32'(bus.g_ina), 0);
    chk("t4_rnd_zero", 32'(bus.g_rnd), 0);
    tick(); bus.rnd_valid = 1'b1;
    @(negedge clk); chk("t4_ina_zero2", 32'(bus.g_ina), 0);
    chk("t4_regrant3", 32'(bus.req_ready), 'b1000);

    // Randomized traffic with sticky requests and rare resets.
    for (int c = 0; c < 10000; c++) begin
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 7) == 0) bus.req_valid[i] = ~bus.req_valid[i];
      end
      bus.rnd_valid = ($urandom_range(0, 9) != 0);
      bus.req_a     = AW'($urandom);
      bus.req_b     = AW'($urandom);
      bus.rnd_in    = RNDW'($urandom);
      rst_n         = ($urandom_range(0, 1499) != 0);
    end

    tick();
    rst_n = 1'b1;
    bus.req_valid = '0;
    repeat (4) tick();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
